// File: rtl/evt_merge_pkg.sv
// evt_merge_pkg: shared FSM state type and saturating-add helper for event_merge_arbiter.
package evt_merge_pkg;
  typedef enum logic {IDLE, PRESENT} state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction
endpackage

// File: rtl/event_merge_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit searching upward from ptr_i+1 with wrap.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             any_o,
  output logic [ID_W-1:0]  idx_o
);
  logic [ID_W-1:0] j;
  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    j = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      j = ID_W'((int'(ptr_i) + k) % N_SRC);
      if (req_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/event_merge_arbiter.sv
// event_merge_arbiter: merges N_SRC single-cycle event sources into one valid/ready stream tagged with source ID.
// Optional EVT_EDGE_DETECT_EN: treat ev_in as levels and fire on rising edges.
module event_merge_arbiter
  import evt_merge_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] ev_in,
  input  logic [N_SRC-1:0] ev_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] ovf,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             drop_clr
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  RR_RST  = ID_W'(N_SRC - 1);
  state_e           state_q, state_d;
  logic [N_SRC-1:0] ev, pend_q, pend_d, clr_v, drop, ovf_q, ovf_d;
  logic [ID_W-1:0]  rr_q, rr_d, id_q, id_d, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any, load;
`ifdef EVT_EDGE_DETECT_EN
  logic [N_SRC-1:0] ev_q;
  // All-ones reset keeps a level already high at reset release from firing.
  always_ff @(posedge clk) ev_q <= rst ? '1 : ev_in;
  assign ev = ev_in & ~ev_q & ~ev_mask;
`else
  assign ev = ev_in & ~ev_mask;
`endif
  rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .req_i(pend_q),
    .ptr_i(rr_q),
    .any_o(any),
    .idx_o(idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= RR_RST;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
    end
  end
  // A new winner loads whenever the output slot is free or being emptied this edge.
  always_comb begin
    load    = any & ((state_q == IDLE) | out_ready);
    state_d = load ? PRESENT : (out_ready ? IDLE : state_q);
  end
  always_comb begin
    clr_v  = load ? (N_SRC'(1) << idx) : '0;
    drop   = ev & pend_q & ~clr_v;
    pend_d = (pend_q & ~clr_v) | ev;
    ovf_d  = (drop_clr ? '0 : ovf_q) | drop;
    cnt_d  = CNT_W'(sat_inc(32'(drop_clr ? '0 : cnt_q), 32'($countones(drop)), 32'(CNT_MAX)));
    rr_d   = load ? idx : rr_q;
    id_d   = load ? idx : id_q;
  end
  always_comb begin
    out_valid = (state_q == PRESENT);
    out_id    = id_q;
    pending   = pend_q;
    ovf       = ovf_q;
    drop_cnt  = cnt_q;
  end
endmodule

// File: tb/tb_event_merge_arbiter.sv
// tb_event_merge_arbiter: directed vector table plus randomized run against a behavioural model.
module tb_event_merge_arbiter;
  logic       clk, rst, out_valid, out_ready, drop_clr;
  logic [3:0] ev_in, ev_mask, pending, ovf;
  logic [1:0] out_id;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  event_merge_arbiter #(.N_SRC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ev_in(ev_in), .ev_mask(ev_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .pending(pending), .ovf(ovf), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic r; logic [3:0] ev, mk; logic rdy, clr;
    logic v; logic [1:0] id; logic [3:0] p, o; logic [7:0] c;
  } vec_t;
  vec_t tbl[$];
  bit [3:0] m_pend, m_ovf;
  bit       m_valid;
  int       m_id, m_rr, m_cnt;
  task automatic add(input logic r, input logic [3:0] ev, mk, input logic rdy, clr,
                     input logic v, input logic [1:0] id, input logic [3:0] p, o, input logic [7:0] c);
    vec_t t;
    t.r = r; t.ev = ev; t.mk = mk; t.rdy = rdy; t.clr = clr;
    t.v = v; t.id = id; t.p = p; t.o = o; t.c = c;
    tbl.push_back(t);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  // Reference: pending set per source, pointer-based fairness, saturating drop total.
  task automatic model_step(input logic r, input logic [3:0] ev, mk, input logic rdy, clr);
    bit [3:0] cap, dr;
    int w, nd;
    if (r) begin
      m_pend = 0; m_ovf = 0; m_valid = 0; m_id = 0; m_rr = 3; m_cnt = 0;
    end else begin
      cap = ev & ~mk; dr = 0; w = -1; nd = 0;
      if (!m_valid || rdy)
        for (int k = 1; k <= 4; k++)
          if (w < 0 && m_pend[(m_rr + k) % 4]) w = (m_rr + k) % 4;
      for (int i = 0; i < 4; i++)
        if (cap[i] && m_pend[i] && w != i) begin dr[i] = 1'b1; nd++; end
      m_cnt = (clr ? 0 : m_cnt) + nd;
      if (m_cnt > 255) m_cnt = 255;
      m_ovf = (clr ? 4'b0 : m_ovf) | dr;
      if (w >= 0) m_pend[w] = 1'b0;
      m_pend = m_pend | cap;
      if (w >= 0) begin m_valid = 1; m_id = w; m_rr = w; end
      else if (rdy) m_valid = 0;
    end
  endtask
  task automatic step(input logic r, input logic [3:0] e, m, input logic rd, c);
    rst = r; ev_in = e; ev_mask = m; out_ready = rd; drop_clr = c;
    @(posedge clk);
    model_step(r, e, m, rd, c);
    #1;
  endtask
  initial begin
    int thr;
    logic [3:0] e, m;
    // reset, single pulse
    add(1, 4'b1111, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 2, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // burst 1011 from reset pointer
    add(1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1011, 0, 1, 0, 0, 0, 4'b1011, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 4'b1010, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 1, 4'b1000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 3, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // backpressure, drop, clear
    add(0, 4'b0010, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 0, 1, 1, 4'b0010, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 0, 1, 1, 4'b0010, 4'b0010, 1);
    add(0, 4'b0000, 0, 0, 1, 1, 1, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // mask
    add(0, 4'b0100, 4'b0100, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 4'b0100, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // fairness
    add(1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 0, 1, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 4'b1110, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 1, 4'b1100, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 2, 4'b1000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 3, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 0, 1, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 4'b1110, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 1, 4'b1100, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 2, 4'b1000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 3, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // same-edge capture and clear is not a drop
    add(0, 4'b0001, 0, 1, 0, 0, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0001, 0, 1, 0, 1, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // drop_clr coinciding with a drop
    add(0, 4'b0011, 0, 0, 0, 0, 0, 4'b0011, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, 1, 1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0001, 0, 0, 0, 1, 1, 4'b0001, 4'b0001, 1);
    add(0, 4'b0010, 0, 0, 0, 1, 1, 4'b0011, 4'b0001, 1);
    add(0, 4'b0010, 0, 0, 1, 1, 1, 4'b0011, 4'b0010, 1);
    // reset mid-operation
    add(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0);
    add(0, 4'b1010, 0, 0, 0, 1, 2, 4'b1010, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, 1, 0, 4'b1110, 4'b0000, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].ev, tbl[i].mk, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec%0d id", i), 32'(out_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].p));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(tbl[i].o));
      chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].c));
    end
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 500) % 3 == 0) ? 90 : ((i / 500) % 3 == 1) ? 50 : 5;
      e = 4'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      step($urandom_range(0, 499) == 0, e, m, $urandom_range(0, 99) < thr, $urandom_range(0, 149) == 0);
      chk("rnd valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("rnd id", 32'(out_id), 32'(m_id));
      chk("rnd pending", 32'(pending), 32'(m_pend));
      chk("rnd ovf", 32'(ovf), 32'(m_ovf));
      chk("rnd drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
